// File: rtl/fifo_serial_tx.sv
// Drains 16-bit words from a FIFO read port and sends each one as an async serial frame:
// start bit, 16 data bits LSB first, optional even parity, stop bit.
module fifo_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [15:0] fifo_dout,
   output logic        fifo_rd_en,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  word_count
);

   localparam int unsigned    BaudW    = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e           state_q, state_d;
   logic             tx_q, tx_d;
   logic [15:0]      shift_q, shift_d;
   logic             parity_q, parity_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [7:0]       word_count_q, word_count_d;
   logic             bit_done;

   assign bit_done = (baud_q == BaudLast);

   always_comb begin
      state_d      = state_q;
      tx_d         = tx_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      bit_cnt_d    = bit_cnt_q;
      baud_d       = baud_q;
      word_count_d = word_count_q;

      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (enable && !fifo_empty) begin
               state_d = StFetch;
            end
         end

         // fifo_dout updates on the edge leaving this state
         StFetch: begin
            state_d = StLoad;
         end

         StLoad: begin
            shift_d   = fifo_dout;
            parity_d  = ^fifo_dout;
            tx_d      = 1'b0;
            baud_d    = '0;
            bit_cnt_d = '0;
            state_d   = StStart;
         end

         StStart: begin
            if (bit_done) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = StData;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         // shift_q[0] is the bit currently on the line; shift_q[1] goes out next
         StData: begin
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[15:1]};
               if (bit_cnt_q == 5'd15) begin
                  bit_cnt_d = '0;
                  if (PARITY_EN) begin
                     tx_d    = parity_q;
                     state_d = StParity;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         StParity: begin
            if (bit_done) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = StStop;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         StStop: begin
            tx_d = 1'b1;
            if (bit_done) begin
               baud_d       = '0;
               word_count_d = word_count_q + 8'd1;
               if (enable && !fifo_empty) begin
                  state_d = StFetch;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         tx_q         <= 1'b1;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         bit_cnt_q    <= '0;
         baud_q       <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         tx_q         <= tx_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         bit_cnt_q    <= bit_cnt_d;
         baud_q       <= baud_d;
         word_count_q <= word_count_d;
      end
   end

   assign fifo_rd_en = (state_q == StFetch);
   assign busy       = (state_q != StIdle);
   assign tx         = tx_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: one instance without parity, one with, each fed by a
// small behavioural FIFO model; 4 clocks per bit.
module tb_fifo_serial_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;

   logic        fifo_empty0, fifo_rd_en0, tx0, busy0;
   logic [15:0] fifo_dout0 = '0;
   logic [7:0]  wc0;
   logic        fifo_empty1, fifo_rd_en1, tx1, busy1;
   logic [15:0] fifo_dout1 = '0;
   logic [7:0]  wc1;

   logic [15:0] mem0 [0:1023];
   logic [15:0] mem1 [0:15];
   int          wr_ptr0 = 0, rd_ptr0 = 0, rd_cnt0 = 0, bad_rd0 = 0;
   int          wr_ptr1 = 0, rd_ptr1 = 0;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  exp_wc0 = '0;

   always #5 clk = ~clk;

   fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty0),
      .fifo_dout(fifo_dout0), .fifo_rd_en(fifo_rd_en0), .tx(tx0), .busy(busy0),
      .word_count(wc0)
   );

   fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty1),
      .fifo_dout(fifo_dout1), .fifo_rd_en(fifo_rd_en1), .tx(tx1), .busy(busy1),
      .word_count(wc1)
   );

   // FIFO models: registered read data, valid the cycle after the strobe
   assign fifo_empty0 = (wr_ptr0 == rd_ptr0);
   assign fifo_empty1 = (wr_ptr1 == rd_ptr1);

   always @(posedge clk) begin
      if (fifo_rd_en0) begin
         rd_cnt0 <= rd_cnt0 + 1;
         if (fifo_empty0) begin
            bad_rd0 <= bad_rd0 + 1;
         end else begin
            fifo_dout0 <= mem0[rd_ptr0];
            rd_ptr0    <= rd_ptr0 + 1;
         end
      end
      if (fifo_rd_en1 && !fifo_empty1) begin
         fifo_dout1 <= mem1[rd_ptr1];
         rd_ptr1    <= rd_ptr1 + 1;
      end
   end

   task automatic push0(input logic [15:0] w);
      mem0[wr_ptr0] = w;
      wr_ptr0++;
   endtask

   task automatic push1(input logic [15:0] w);
      mem1[wr_ptr1] = w;
      wr_ptr1++;
   endtask

   // Waits (bounded) for the start bit, then samples nbits bits of 4 cycles each.
   // gap = negedges waited before the start bit; glitch = tx changed inside a bit.
   task automatic capture_frame(input bit sel, input int nbits, output logic [31:0] bits,
                                output int gap, output bit glitch);
      logic v, cur;
      gap    = 0;
      glitch = 1'b0;
      bits   = '0;
      v      = 1'b0;
      cur    = sel ? tx1 : tx0;
      while (cur !== 1'b0 && gap < 200) begin
         @(negedge clk);
         gap++;
         cur = sel ? tx1 : tx0;
      end
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < 4; c++) begin
            cur = sel ? tx1 : tx0;
            if (c == 0) begin
               v       = cur;
               bits[b] = cur;
            end else if (cur !== v) begin
               glitch = 1'b1;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_idle0(input int limit, output bit timed_out);
      int n = 0;
      while (busy0 !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      timed_out = (busy0 !== 1'b0);
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx0); end
      n_checks++;
      if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
      n_checks++;
      if (fifo_rd_en0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en0);
      end
      n_checks++;
      if (wc0 !== 8'd0) begin n_fail++; $display("FAIL reset_wc: got %0d want 0", wc0); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx0, busy0);
      end
   endtask

   task automatic test_single;
      logic [31:0] bits, exp;
      int          gap, rd_before;
      bit          gl;
      enable    = 1'b1;
      rd_before = rd_cnt0;
      push0(16'hA5C3);
      capture_frame(1'b0, 18, bits, gap, gl);
      exp_wc0 = exp_wc0 + 8'd1;
      exp = {14'd0, 1'b1, 16'hA5C3, 1'b0};
      n_checks++;
      if (gap !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", gap); end
      n_checks++;
      if (bits !== exp) begin n_fail++; $display("FAIL single_bits: got %h want %h", bits, exp); end
      n_checks++;
      if (gl !== 1'b0) begin n_fail++; $display("FAIL single_bit_width: tx changed mid-bit"); end
      n_checks++;
      if (rd_cnt0 - rd_before !== 1) begin
         n_fail++; $display("FAIL single_rd_cycles: got %0d want 1", rd_cnt0 - rd_before);
      end
      n_checks++;
      if (wc0 !== exp_wc0) begin n_fail++; $display("FAIL single_wc: got %0d want %0d", wc0, exp_wc0); end
      n_checks++;
      if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
         n_fail++; $display("FAIL single_end: busy=%b tx=%b want busy=0 tx=1", busy0, tx0);
      end
   endtask

   task automatic test_parity;
      logic [31:0] bits, exp;
      int          gap;
      bit          gl;
      enable = 1'b1;
      push1(16'hA5C3);
      capture_frame(1'b1, 19, bits, gap, gl);
      exp = {13'd0, 1'b1, 1'b0, 16'hA5C3, 1'b0};
      n_checks++;
      if (bits !== exp || gl !== 1'b0 || gap !== 3) begin
         n_fail++;
         $display("FAIL parity0_frame: got %h gap %0d glitch %b want %h gap 3", bits, gap, gl, exp);
      end
      push1(16'h0001);
      capture_frame(1'b1, 19, bits, gap, gl);
      exp = {13'd0, 1'b1, 1'b1, 16'h0001, 1'b0};
      n_checks++;
      if (bits !== exp || gl !== 1'b0) begin
         n_fail++; $display("FAIL parity1_frame: got %h glitch %b want %h", bits, gl, exp);
      end
      n_checks++;
      if (wc1 !== 8'd2 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL parity_end: wc=%0d busy=%b want wc=2 busy=0", wc1, busy1);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] words [0:7];
      logic [31:0] bits, exp;
      int          gap, rd_before;
      bit          gl;
      words = '{16'h0000, 16'hFFFF, 16'h8001, 16'h1234, 16'hFEDC, 16'h5555, 16'hAAAA, 16'h0F0F};
      enable    = 1'b1;
      rd_before = rd_cnt0;
      for (int i = 0; i < 8; i++) push0(words[i]);
      for (int f = 0; f < 8; f++) begin
         capture_frame(1'b0, 18, bits, gap, gl);
         exp_wc0 = exp_wc0 + 8'd1;
         exp = {14'd0, 1'b1, words[f], 1'b0};
         n_checks++;
         if (bits !== exp || gl !== 1'b0) begin
            n_fail++; $display("FAIL b2b_frame%0d: got %h glitch %b want %h", f, bits, gl, exp);
         end
         if (f > 0) begin
            n_checks++;
            if (gap !== 2) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 2", f, gap); end
         end
      end
      n_checks++;
      if (wc0 !== exp_wc0) begin n_fail++; $display("FAIL b2b_wc: got %0d want %0d", wc0, exp_wc0); end
      n_checks++;
      if (fifo_empty0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL b2b_end: empty=%b busy=%b want 1 0", fifo_empty0, busy0);
      end
      n_checks++;
      if (bad_rd0 !== 0 || rd_cnt0 - rd_before !== 8) begin
         n_fail++;
         $display("FAIL b2b_rd: reads=%0d on_empty=%0d want 8 and 0", rd_cnt0 - rd_before, bad_rd0);
      end
   endtask

   task automatic test_enable;
      int rd_before;
      bit to;
      enable = 1'b0;
      push0(16'h1234);
      push0(16'h5678);
      rd_before = rd_cnt0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (rd_cnt0 !== rd_before || tx0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL en_off_idle: reads=%0d tx=%b busy=%b want 0 1 0", rd_cnt0 - rd_before, tx0, busy0);
      end
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fifo_rd_en0 !== 1'b1) begin n_fail++; $display("FAIL en_fetch: rd_en=%b want 1", fifo_rd_en0); end
      // FETCH -> LOAD -> 4 start cycles -> middle of data bit 3
      repeat (1 + 4 + 12 + 2) @(negedge clk);
      enable = 1'b0;
      wait_idle0(200, to);
      exp_wc0 = exp_wc0 + 8'd1;
      n_checks++;
      if (to || wc0 !== exp_wc0) begin
         n_fail++; $display("FAIL en_drop_complete: timeout=%b wc=%0d want 0 %0d", to, wc0, exp_wc0);
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (rd_cnt0 - rd_before !== 1 || fifo_empty0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop_no_fetch: reads=%0d empty=%b busy=%b want 1 0 0",
                  rd_cnt0 - rd_before, fifo_empty0, busy0);
      end
      enable = 1'b1;
      repeat (2) @(negedge clk);
      wait_idle0(200, to);
      exp_wc0 = exp_wc0 + 8'd1;
      n_checks++;
      if (to || wc0 !== exp_wc0 || fifo_empty0 !== 1'b1) begin
         n_fail++;
         $display("FAIL en_drain: timeout=%b wc=%0d empty=%b want 0 %0d 1", to, wc0, fifo_empty0, exp_wc0);
      end
   endtask

   task automatic test_reset_mid;
      int n, rd_before;
      enable = 1'b1;
      push0(16'h0000);
      n = 0;
      while (tx0 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (4 + 28 + 2) @(negedge clk);
      n_checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         n_fail++; $display("FAIL mid_bit7: tx=%b busy=%b want 0 1", tx0, busy0);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || wc0 !== 8'd0) begin
         n_fail++; $display("FAIL async_reset: tx=%b busy=%b wc=%0d want 1 0 0", tx0, busy0, wc0);
      end
      @(negedge clk);
      rst       = 1'b0;
      exp_wc0   = 8'd0;
      rd_before = rd_cnt0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (busy0 !== 1'b0 || tx0 !== 1'b1 || rd_cnt0 !== rd_before || fifo_empty0 !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: busy=%b tx=%b reads=%0d empty=%b want 0 1 0 1",
                  busy0, tx0, rd_cnt0 - rd_before, fifo_empty0);
      end
   endtask

   task automatic test_wrap;
      int rd_before;
      bit to;
      enable    = 1'b1;
      rd_before = rd_cnt0;
      for (int i = 0; i < 256; i++) begin
         push0(16'(i * 257) ^ 16'h5A5A);
         exp_wc0 = exp_wc0 + 8'd1;
      end
      repeat (2) @(negedge clk);
      wait_idle0(256 * 80, to);
      n_checks++;
      if (to || wc0 !== exp_wc0) begin
         n_fail++; $display("FAIL wrap_wc: timeout=%b wc=%0d want 0 %0d", to, wc0, exp_wc0);
      end
      n_checks++;
      if (rd_cnt0 - rd_before !== 256 || bad_rd0 !== 0) begin
         n_fail++;
         $display("FAIL wrap_reads: reads=%0d on_empty=%0d want 256 0", rd_cnt0 - rd_before, bad_rd0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Reader-side consumer for the 16-bit x 8 FIFO buffer. It drains words from the FIFO read port, then shifts each word out on a single asynchronous-serial line with start, optional parity and stop bits. Its fifo_* ports connect directly to the FIFO's rd_en, empty and buff_out. This block is the transmit end of the board's serial data link.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal minimum 2.
PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
enable  input  1  permits starting new frames; sampled only in IDLE and at the end of STOP.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  16  FIFO registered read data; valid the cycle after a fifo_rd_en pulse.
fifo_rd_en  output  1  one-cycle read strobe to the FIFO.
tx  output  1  serial line, registered, idles high.
busy  output  1  high from FETCH through the end of STOP.
word_count  output  8  number of frames completed; wraps 255 -> 0.

Behaviour:
- Reset (async): state=IDLE, tx=1, busy=0, fifo_rd_en=0, word_count=0, shift register=0, bit and baud counters=0. Reset mid-frame forces tx=1 immediately. The partially sent word is lost and is not re-read.
- fifo_rd_en = (state==FETCH), combinational decode. It is high for exactly 1 cycle per word and is never asserted while fifo_empty=1.
- IDLE: tx=1, busy=0. If enable && !fifo_empty, go to FETCH; otherwise stay in IDLE.
- FETCH (1 cycle): rd_en pulses and the FIFO updates fifo_dout on this edge. Go to LOAD.
- LOAD (1 cycle):
  - shift_reg <= fifo_dout.
  - parity bit <= ^fifo_dout (even parity: the parity bit is 1 when the data has an odd number of 1s).
  - tx <= 0 (start bit).
  - baud counter cleared. Go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles, counted from the edge leaving LOAD. Then go to DATA, with tx <= shift_reg[0].
- DATA: 16 bits, LSB first. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right and the 5-bit bit counter increments. After bit 15, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle:
  - word_count increments.
  - If enable && !fifo_empty, go directly to FETCH (back-to-back frames: 2 cycles of stop-level idle, FETCH + LOAD, before the next start bit).
  - Otherwise go to IDLE.
- Latency: with data present in IDLE, tx falls 2 edges after the IDLE->FETCH transition edge. Frame length is (18 + PARITY_EN) * CLKS_PER_BIT cycles, measured from the tx falling edge.
- enable deasserted mid-frame: the current frame completes normally, and no new FETCH follows.
- FIFO written while a frame is in progress: no effect until the STOP decision point.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads to 0 at every bit boundary.

Test Plan:
1. Reset, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 16'hA5C3, enable=1 -> rd_en is a single 1-cycle pulse. tx reads 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, each bit for 4 cycles (72 cycles total). word_count=1, busy falls.
2. Same word with PARITY_EN=1 -> parity bit 0 is inserted after data bit 15, frame is 76 cycles. Repeat with 16'h0001 -> parity bit 1.
3. FIFO holds 8 words (full), enable=1 -> 8 back-to-back frames, each separated by exactly 2 idle-high cycles. At the end word_count=8, fifo_empty=1, and rd_en is never high while empty.
4. enable=0 with FIFO non-empty -> no rd_en, tx=1, busy=0. Raise enable -> FETCH on the next cycle. Drop enable during frame 1 DATA -> frame 1 completes, no second rd_en.
5. Assert rst in the middle of DATA bit 7 -> tx=1 and busy=0 with no clock edge required. After release with FIFO empty, the block remains in IDLE.
6. Send 256 frames -> word_count wraps to 0.
